// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default tuning constants for the pixel-SRAM port arbiter.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACC = 2'd1,
        WR_ACC = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_RD = 1'b0,
        OWN_WR = 1'b1
    } owner_t;

    localparam int DEF_MAX_BURST = 9;
    localparam int DEF_TIMEOUT   = 16;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_RD) ? OWN_WR : OWN_RD;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled for connection.
// Handshake: a requester raises *_req with stable addr/data and holds it until
// a one-cycle *_done or *_err pulse; the memory finishes an access in any cycle
// where mem_ready is high while a strobe is asserted.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              rd_req;
    logic              rd_lock;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic [DATA_W-1:0] rd_rdata;
    logic              rd_err;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_wdata;
    logic              wr_done;
    logic              wr_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  rd_req, rd_lock, rd_addr, wr_req, wr_addr, wr_wdata, mem_rdata, mem_ready,
        output rd_done, rd_rdata, rd_err, wr_done, wr_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_lock, rd_addr, wr_req, wr_addr, wr_wdata, mem_rdata, mem_ready,
        input  rd_done, rd_rdata, rd_err, wr_done, wr_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for the single pixel-SRAM port: reader bursts under lock,
// capped at MAX_BURST while the writer waits; accesses abort after TIMEOUT cycles.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    sram_port_arbiter_if.slave  bus,
    output arb_state_t          dbg_state
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    arb_state_t    state_q, state_d;
    owner_t        last_owner_q, last_owner_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    logic   in_acc;
    logic   timeout_hit;
    logic   finish;
    logic   lock_held;
    owner_t cur_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= OWN_WR;
            burst_cnt_q  <= '0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign in_acc      = (state_q != IDLE);
    assign cur_owner   = (state_q == WR_ACC) ? OWN_WR : OWN_RD;
    // Completion beats timeout when mem_ready arrives on the last allowed cycle.
    assign timeout_hit = in_acc && !bus.mem_ready && (to_cnt_q == TO_LAST);
    assign finish      = in_acc && (bus.mem_ready || timeout_hit);
    // Only the reader can lock; the cap applies only when the writer is contending.
    assign lock_held   = (last_owner_q == OWN_RD) && bus.rd_lock && (burst_cnt_q < BURST_MAX);

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        to_cnt_d     = to_cnt_q;
        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (bus.rd_req && bus.wr_req) begin
                    if (lock_held) state_d = RD_ACC;
                    else state_d = (other_owner(last_owner_q) == OWN_RD) ? RD_ACC : WR_ACC;
                end else if (bus.rd_req) begin
                    state_d = RD_ACC;
                end else if (bus.wr_req) begin
                    state_d = WR_ACC;
                end
            end
            RD_ACC, WR_ACC: begin
                if (finish) begin
                    state_d      = IDLE;
                    last_owner_d = cur_owner;
                    if (cur_owner != last_owner_q) burst_cnt_d = BW'(1);
                    else if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + BW'(1);
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read  = (state_q == RD_ACC);
    assign bus.mem_write = (state_q == WR_ACC);
    assign bus.mem_addr  = (state_q == RD_ACC) ? bus.rd_addr :
                           (state_q == WR_ACC) ? bus.wr_addr : '0;
    assign bus.mem_wdata = (state_q == WR_ACC) ? bus.wr_wdata : '0;
    assign bus.rd_done   = (state_q == RD_ACC) && bus.mem_ready;
    assign bus.wr_done   = (state_q == WR_ACC) && bus.mem_ready;
    assign bus.rd_rdata  = bus.rd_done ? bus.mem_rdata : '0;
    assign bus.rd_err    = (state_q == RD_ACC) && timeout_hit;
    assign bus.wr_err    = (state_q == WR_ACC) && timeout_hit;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, wait states, alternation,
// locked bursts with cap, timeout abort and the completion-vs-timeout boundary.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    arb_state_t dbg_state;
    int         n_checks;
    int         n_errors;
    logic [1:0] exp_q[$];
    logic [1:0] exp_s;

    sram_port_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    sram_port_arbiter #(
        .ADDR_W(16), .DATA_W(8), .MAX_BURST(9), .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.rd_req = 0; bus.rd_lock = 0; bus.rd_addr = '0;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", dbg_state, IDLE);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        rst = 1'b0;

        // Reset in the middle of a write access
        bus.wr_req = 1; bus.wr_addr = 16'h0123; bus.wr_wdata = 8'h55;
        tick();
        chk("t1_wr_strobe", bus.mem_write, 1);
        chk("t1_wr_addr", bus.mem_addr, 16'h0123);
        chk("t1_wr_wdata", bus.mem_wdata, 8'h55);
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_write", bus.mem_write, 0);
        chk("t1_rst_addr", bus.mem_addr, 0);
        chk("t1_rst_wdata", bus.mem_wdata, 0);
        chk("t1_rst_done", bus.wr_done, 0);
        chk("t1_rst_err", bus.wr_err, 0);
        chk("t1_rst_state", dbg_state, IDLE);
        bus.wr_req = 0;
        tick();
        rst = 1'b0;

        // First contested grant after reset goes to the reader
        bus.rd_req = 1; bus.rd_addr = 16'h0040;
        bus.wr_req = 1; bus.wr_addr = 16'h0124; bus.wr_wdata = 8'h66;
        #1 chk("t1_contest_idle", dbg_state, IDLE);
        tick();
        chk("t1_contest_rd", dbg_state, RD_ACC);
        chk("t1_contest_read", bus.mem_read, 1);
        bus.mem_ready = 1; bus.mem_rdata = 8'h11;
        #1;
        chk("t1_rd_done", bus.rd_done, 1);
        chk("t1_rd_rdata", bus.rd_rdata, 8'h11);
        chk("t1_wr_done_quiet", bus.wr_done, 0);
        bus.rd_req = 0;
        tick();
        chk("t1_idle_after_rd", dbg_state, IDLE);
        chk("t1_ready_ignored", bus.rd_done, 0);
        tick();
        chk("t1_wr_grant", dbg_state, WR_ACC);
        chk("t1_wr_done", bus.wr_done, 1);
        bus.wr_req = 0;
        tick();
        bus.mem_ready = 0;

        // Read with two wait states
        bus.rd_req = 1; bus.rd_addr = 16'h0010;
        tick();
        chk("t2_c1_read", bus.mem_read, 1);
        chk("t2_c1_addr", bus.mem_addr, 16'h0010);
        chk("t2_c1_done", bus.rd_done, 0);
        tick();
        chk("t2_c2_read", bus.mem_read, 1);
        chk("t2_c2_done", bus.rd_done, 0);
        tick();
        bus.mem_ready = 1; bus.mem_rdata = 8'hAB;
        #1;
        chk("t2_c3_read", bus.mem_read, 1);
        chk("t2_c3_done", bus.rd_done, 1);
        chk("t2_c3_rdata", bus.rd_rdata, 8'hAB);
        bus.rd_req = 0;
        tick();
        bus.mem_ready = 0; bus.mem_rdata = '0;
        #1;
        chk("t2_idle", dbg_state, IDLE);
        chk("t2_idle_read", bus.mem_read, 0);
        chk("t2_idle_done", bus.rd_done, 0);

        // Write timeout; a read raised meanwhile is served first afterwards
        bus.wr_req = 1; bus.wr_addr = 16'h0300; bus.wr_wdata = 8'h77;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 3) begin
                bus.rd_req = 1; bus.rd_addr = 16'h0050;
            end
            #1;
            chk("t5_write_strobe", bus.mem_write, 1);
            chk("t5_wr_err", bus.wr_err, (c == 16));
            chk("t5_wr_done", bus.wr_done, 0);
        end
        tick();
        chk("t5_idle", dbg_state, IDLE);
        chk("t5_strobe_drop", bus.mem_write, 0);
        chk("t5_err_drop", bus.wr_err, 0);
        tick();
        chk("t5_rd_first", dbg_state, RD_ACC);
        bus.mem_ready = 1; bus.mem_rdata = 8'h5A;
        #1;
        chk("t5_rd_done", bus.rd_done, 1);
        chk("t5_rd_rdata", bus.rd_rdata, 8'h5A);
        bus.rd_req = 0;
        tick();
        tick();
        chk("t5_wr_retry", dbg_state, WR_ACC);
        chk("t5_wr_retry_done", bus.wr_done, 1);
        chk("t5_wr_retry_err", bus.wr_err, 0);
        bus.wr_req = 0;
        tick();
        bus.mem_ready = 0;

        // Both requesting, no lock, zero wait states: strict alternation
        exp_q.push_back(RD_ACC); exp_q.push_back(WR_ACC);
        exp_q.push_back(RD_ACC); exp_q.push_back(WR_ACC);
        bus.rd_req = 1; bus.rd_addr = 16'h0060;
        bus.wr_req = 1; bus.wr_addr = 16'h0310; bus.wr_wdata = 8'h12;
        bus.mem_ready = 1;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("t3_idle", dbg_state, IDLE);
            chk("t3_idle_rd_done", bus.rd_done, 0);
            chk("t3_idle_wr_done", bus.wr_done, 0);
            tick();
            exp_s = exp_q.pop_front();
            chk("t3_grant", dbg_state, exp_s);
            chk("t3_rd_done", bus.rd_done, (exp_s == RD_ACC));
            chk("t3_wr_done", bus.wr_done, (exp_s == WR_ACC));
            if (g == 3) begin
                bus.rd_req = 0; bus.wr_req = 0;
            end
            tick();
        end
        bus.mem_ready = 0;

        // Locked read burst of 12 with writer waiting: 9 reads, 1 write, 3 reads
        for (int i = 0; i < 9; i++) exp_q.push_back(RD_ACC);
        exp_q.push_back(WR_ACC);
        for (int i = 0; i < 3; i++) exp_q.push_back(RD_ACC);
        bus.rd_lock = 1; bus.rd_req = 1; bus.rd_addr = 16'h0100;
        bus.wr_req = 1; bus.wr_addr = 16'h0200; bus.wr_wdata = 8'h3F;
        bus.mem_ready = 1; bus.mem_rdata = 8'hC3;
        for (int g = 0; g < 13; g++) begin
            exp_s = exp_q.pop_front();
            tick();
            chk("t4_grant", dbg_state, exp_s);
            if (exp_s == WR_ACC) begin
                chk("t4_wr_addr", bus.mem_addr, 16'h0200);
                chk("t4_wr_wdata", bus.mem_wdata, 8'h3F);
                chk("t4_wr_done", bus.wr_done, 1);
                bus.wr_req = 0;
            end else begin
                chk("t4_rd_done", bus.rd_done, 1);
            end
            tick();
            chk("t4_idle", dbg_state, IDLE);
        end
        bus.rd_req = 0; bus.rd_lock = 0; bus.mem_ready = 0;

        // mem_ready on the last allowed cycle completes instead of aborting
        bus.wr_req = 1; bus.wr_addr = 16'h0400; bus.wr_wdata = 8'h99;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 16) bus.mem_ready = 1;
            #1;
            chk("t6_wr_err", bus.wr_err, 0);
            chk("t6_wr_done", bus.wr_done, (c == 16));
        end
        bus.wr_req = 0;
        tick();
        bus.mem_ready = 0;
        #1;
        chk("t6_idle", dbg_state, IDLE);
        chk("t6_err_after", bus.wr_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
